// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (core LSU, debug loader), the arbiter
// and the shared data-memory/IO port.
interface dmem_arbiter_if;
   // core requester
   logic        c_req_i;
   logic        c_we_i;
   logic [31:0] c_addr_i;
   logic [31:0] c_wdata_i;
   logic [3:0]  c_be_i;
   logic        c_gnt_o;
   logic        c_rvalid_o;
   logic [31:0] c_rdata_o;
   // debug / program-loader requester
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [3:0]  d_be_i;
   logic        d_gnt_o;
   logic        d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        dbg_lock_i;
   // memory side
   logic        m_req_o;
   logic        m_we_o;
   logic [31:0] m_addr_o;
   logic [31:0] m_wdata_o;
   logic [3:0]  m_be_o;
   logic [31:0] m_rdata_i;
   logic        busy_o;

   modport slave (
      input  c_req_i, c_we_i, c_addr_i, c_wdata_i, c_be_i,
      output c_gnt_o, c_rvalid_o, c_rdata_o,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
      output d_gnt_o, d_rvalid_o, d_rdata_o,
      input  dbg_lock_i,
      output m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
      input  m_rdata_i,
      output busy_o
   );

   modport master (
      output c_req_i, c_we_i, c_addr_i, c_wdata_i, c_be_i,
      input  c_gnt_o, c_rvalid_o, c_rdata_o,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
      input  d_gnt_o, d_rvalid_o, d_rdata_o,
      output dbg_lock_i,
      input  m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
      output m_rdata_i,
      input  busy_o
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data-memory port: core has fixed priority,
// debug is protected from starvation, one transaction outstanding at a time.
module dmem_arbiter #(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   dmem_arbiter_if.slave bus
);

   localparam int unsigned WAIT_W   = 3;
   localparam int unsigned STARVE_W = 4;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned BE_W     = 4;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                owner_q, owner_d;  // 1: debug port owns the transaction
   logic                we_q, we_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                c_rvalid_q, c_rvalid_d;
   logic                d_rvalid_q, d_rvalid_d;

   logic                c_elig, d_elig, pick_d;
   logic                c_gnt_c, d_gnt_c;
   logic                m_req_c, m_we_c;
   logic [DATA_W-1:0]   m_addr_c, m_wdata_c;
   logic [BE_W-1:0]     m_be_c;

   // State and transaction bookkeeping registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         starve_q   <= '0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         rdata_q    <= '0;
         c_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         starve_q   <= starve_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         rdata_q    <= rdata_d;
         c_rvalid_q <= c_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
      end
   end

   // Arbitration, grant/command generation and completion
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      starve_d   = starve_q;
      owner_d    = owner_q;
      we_d       = we_q;
      rdata_d    = rdata_q;
      c_rvalid_d = 1'b0;
      d_rvalid_d = 1'b0;
      c_gnt_c    = 1'b0;
      d_gnt_c    = 1'b0;
      m_req_c    = 1'b0;
      m_we_c     = 1'b0;
      m_addr_c   = '0;
      m_wdata_c  = '0;
      m_be_c     = '0;

      // Grants are combinational, so hold them off while reset is asserted
      c_elig = bus.c_req_i && !bus.dbg_lock_i && !rst_i;
      d_elig = bus.d_req_i && !rst_i;
      pick_d = d_elig && (!c_elig || (starve_q == STARVE_W'(STARVE_MAX)));

      case (state_q)
         IDLE: begin
            if (c_elig || d_elig) begin
               c_gnt_c   = !pick_d;
               d_gnt_c   = pick_d;
               m_req_c   = 1'b1;
               m_we_c    = pick_d ? bus.d_we_i    : bus.c_we_i;
               m_addr_c  = pick_d ? bus.d_addr_i  : bus.c_addr_i;
               m_wdata_c = pick_d ? bus.d_wdata_i : bus.c_wdata_i;
               m_be_c    = pick_d ? bus.d_be_i    : bus.c_be_i;
               owner_d   = pick_d;
               we_d      = m_we_c;
               wait_d    = WAIT_W'(MEM_LAT);
               state_d   = WAIT;
               if (pick_d || !bus.d_req_i) begin
                  starve_d = '0;
               end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                  starve_d = starve_q + 1'b1;
               end
            end
         end
         WAIT: begin
            wait_d = wait_q - 1'b1;
            if (wait_q == WAIT_W'(1)) begin
               state_d    = IDLE;
               rdata_d    = we_q ? '0 : bus.m_rdata_i;
               c_rvalid_d = !owner_q;
               d_rvalid_d = owner_q;
            end
         end
      endcase
   end

   assign bus.c_gnt_o    = c_gnt_c;
   assign bus.d_gnt_o    = d_gnt_c;
   assign bus.m_req_o    = m_req_c;
   assign bus.m_we_o     = m_we_c;
   assign bus.m_addr_o   = m_addr_c;
   assign bus.m_wdata_o  = m_wdata_c;
   assign bus.m_be_o     = m_be_c;
   assign bus.c_rvalid_o = c_rvalid_q;
   assign bus.d_rvalid_o = d_rvalid_q;
   assign bus.c_rdata_o  = rdata_q;
   assign bus.d_rdata_o  = rdata_q;
   assign bus.busy_o     = (state_q == WAIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance at MEM_LAT=1/STARVE_MAX=4,
// one at MEM_LAT=3/STARVE_MAX=1, sharing clock and reset.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          cyc;
      bit          d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } gexp_t;

   typedef struct {
      int          cyc;
      bit          d;
      logic [31:0] data;
   } rexp_t;

   gexp_t gq1[$], gq3[$];
   rexp_t rq1[$], rq3[$];

   dmem_arbiter_if b1 ();
   dmem_arbiter_if b3 ();

   dmem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));
   dmem_arbiter #(.MEM_LAT(3), .STARVE_MAX(1)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      case (a)
         32'h0000_0010: mem_val = 32'hDEAD_BEEF;
         32'h0000_0020: mem_val = 32'hCAFE_0001;
         default:       mem_val = a ^ 32'h5A5A_0000;
      endcase
   endfunction

   // Memory: read data is valid only in the cycle MEM_LAT after the command
   logic [2:0]  cnt1 = 3'd0, cnt3 = 3'd0;
   logic [31:0] maddr1 = '0, maddr3 = '0;
   always @(posedge clk) begin
      if (rst) begin
         cnt1 <= 3'd0;
         cnt3 <= 3'd0;
      end else begin
         if (b1.m_req_o && !b1.m_we_o) begin
            cnt1 <= 3'd1; maddr1 <= b1.m_addr_o;
         end else if (cnt1 != 3'd0) cnt1 <= cnt1 - 3'd1;
         if (b3.m_req_o && !b3.m_we_o) begin
            cnt3 <= 3'd3; maddr3 <= b3.m_addr_o;
         end else if (cnt3 != 3'd0) cnt3 <= cnt3 - 3'd1;
      end
   end
   assign b1.m_rdata_i = (cnt1 == 3'd1) ? mem_val(maddr1) : 32'hBAD0_BAD0;
   assign b3.m_rdata_i = (cnt3 == 3'd1) ? mem_val(maddr3) : 32'hBAD0_BAD0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_g(input int dut, input int c, input bit d, input bit we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      gexp_t e;
      e = '{c, d, we, a, wd, be};
      if (dut == 1) gq1.push_back(e); else gq3.push_back(e);
   endtask

   task automatic push_r(input int dut, input int c, input bit d, input logic [31:0] data);
      rexp_t e;
      e = '{c, d, data};
      if (dut == 1) rq1.push_back(e); else rq3.push_back(e);
   endtask

   task automatic mon_gnt(input string tag, input logic cg, input logic dg, input logic mreq,
                          input logic mwe, input logic [31:0] ma, input logic [31:0] mwd,
                          input logic [3:0] mbe, input bit have, input gexp_t e);
      if (!(cg || dg)) begin
         chk({tag, "_m_idle"}, ma | mwd | {26'b0, mreq, mwe, mbe}, 32'd0);
      end else if (!have) begin
         chk({tag, "_gnt_unexpected"}, {30'b0, cg, dg}, 32'd0);
      end else begin
         chk({tag, "_gnt_cycle"}, 32'(cyc), 32'(e.cyc));
         chk({tag, "_gnt_port"}, {30'b0, cg, dg}, e.d ? 32'd1 : 32'd2);
         chk({tag, "_m_req"}, {31'b0, mreq}, 32'd1);
         chk({tag, "_m_we"}, {31'b0, mwe}, {31'b0, e.we});
         chk({tag, "_m_addr"}, ma, e.addr);
         chk({tag, "_m_wdata"}, mwd, e.wdata);
         chk({tag, "_m_be"}, {28'b0, mbe}, {28'b0, e.be});
      end
   endtask

   task automatic mon_rsp(input string tag, input logic cv, input logic dv,
                          input logic [31:0] crd, input logic [31:0] drd,
                          input bit have, input rexp_t e);
      if (!(cv || dv)) return;
      if (!have) begin
         chk({tag, "_rvalid_unexpected"}, {30'b0, cv, dv}, 32'd0);
      end else begin
         chk({tag, "_rvalid_cycle"}, 32'(cyc), 32'(e.cyc));
         chk({tag, "_rvalid_port"}, {30'b0, cv, dv}, e.d ? 32'd1 : 32'd2);
         chk({tag, "_c_rdata"}, crd, e.data);
         chk({tag, "_d_rdata"}, drd, e.data);
      end
   endtask

   // Monitors: pop the scoreboard whenever a DUT shows a grant or completion
   always @(negedge clk) begin
      gexp_t ge; rexp_t re; bit hg, hr;
      if (!rst) begin
         hg = 1'b0; hr = 1'b0;
         if ((b1.c_gnt_o || b1.d_gnt_o) && gq1.size() > 0) begin hg = 1'b1; ge = gq1.pop_front(); end
         if ((b1.c_rvalid_o || b1.d_rvalid_o) && rq1.size() > 0) begin hr = 1'b1; re = rq1.pop_front(); end
         mon_gnt("p1", b1.c_gnt_o, b1.d_gnt_o, b1.m_req_o, b1.m_we_o, b1.m_addr_o,
                 b1.m_wdata_o, b1.m_be_o, hg, ge);
         mon_rsp("p1", b1.c_rvalid_o, b1.d_rvalid_o, b1.c_rdata_o, b1.d_rdata_o, hr, re);
      end
   end

   always @(negedge clk) begin
      gexp_t ge; rexp_t re; bit hg, hr;
      if (!rst) begin
         hg = 1'b0; hr = 1'b0;
         if ((b3.c_gnt_o || b3.d_gnt_o) && gq3.size() > 0) begin hg = 1'b1; ge = gq3.pop_front(); end
         if ((b3.c_rvalid_o || b3.d_rvalid_o) && rq3.size() > 0) begin hr = 1'b1; re = rq3.pop_front(); end
         mon_gnt("p3", b3.c_gnt_o, b3.d_gnt_o, b3.m_req_o, b3.m_we_o, b3.m_addr_o,
                 b3.m_wdata_o, b3.m_be_o, hg, ge);
         mon_rsp("p3", b3.c_rvalid_o, b3.d_rvalid_o, b3.c_rdata_o, b3.d_rdata_o, hr, re);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      b1.c_req_i = 0; b1.c_we_i = 0; b1.c_addr_i = '0; b1.c_wdata_i = '0; b1.c_be_i = '0;
      b1.d_req_i = 0; b1.d_we_i = 0; b1.d_addr_i = '0; b1.d_wdata_i = '0; b1.d_be_i = '0;
      b1.dbg_lock_i = 0;
      b3.c_req_i = 0; b3.c_we_i = 0; b3.c_addr_i = '0; b3.c_wdata_i = '0; b3.c_be_i = '0;
      b3.d_req_i = 0; b3.d_we_i = 0; b3.d_addr_i = '0; b3.d_wdata_i = '0; b3.d_be_i = '0;
      b3.dbg_lock_i = 0;

      tick(2);
      chk("rst_busy1", {31'b0, b1.busy_o}, 32'd0);
      chk("rst_rvalid1", {30'b0, b1.c_rvalid_o, b1.d_rvalid_o}, 32'd0);
      chk("rst_rdata1", b1.c_rdata_o | b1.d_rdata_o, 32'd0);
      chk("rst_busy3", {31'b0, b3.busy_o}, 32'd0);
      rst = 1'b0;
      tick(1);

      // Core read, MEM_LAT=1
      t = cyc;
      b1.c_we_i = 0; b1.c_addr_i = 32'h10; b1.c_wdata_i = 32'h1111_2222; b1.c_be_i = 4'hF;
      b1.c_req_i = 1;
      push_g(1, t, 0, 0, 32'h10, 32'h1111_2222, 4'hF);
      push_r(1, t + 2, 0, 32'hDEAD_BEEF);
      tick(1);
      b1.c_req_i = 0;
      tick(3);

      // Both requesting continuously: debug gets every fifth grant
      t = cyc;
      b1.c_addr_i = 32'h100; b1.c_wdata_i = 32'h0;
      b1.d_we_i = 0; b1.d_addr_i = 32'h200; b1.d_wdata_i = 32'h33; b1.d_be_i = 4'hF;
      b1.c_req_i = 1; b1.d_req_i = 1;
      for (int i = 0; i < 10; i++) begin
         bit dsel;
         dsel = (i == 4) || (i == 9);
         push_g(1, t + 2 * i, dsel, 0, dsel ? 32'h200 : 32'h100, dsel ? 32'h33 : 32'h0, 4'hF);
         push_r(1, t + 2 * i + 2, dsel, mem_val(dsel ? 32'h200 : 32'h100));
      end
      tick(19);
      b1.c_req_i = 0; b1.d_req_i = 0;
      tick(3);

      // Loader lock: only debug is served, then the core wins once unlocked
      t = cyc;
      b1.dbg_lock_i = 1;
      b1.c_req_i = 1; b1.d_req_i = 1;
      for (int i = 0; i < 10; i++) begin
         push_g(1, t + 2 * i, 1, 0, 32'h200, 32'h33, 4'hF);
         push_r(1, t + 2 * i + 2, 1, mem_val(32'h200));
      end
      push_g(1, t + 20, 0, 0, 32'h100, 32'h0, 4'hF);
      push_r(1, t + 22, 0, mem_val(32'h100));
      tick(19);
      b1.dbg_lock_i = 0;
      tick(2);
      b1.c_req_i = 0; b1.d_req_i = 0;
      tick(3);

      // Debug write returns zero data
      t = cyc;
      b1.d_we_i = 1; b1.d_addr_i = 32'h2000; b1.d_wdata_i = 32'h1234_5678; b1.d_be_i = 4'hF;
      b1.d_req_i = 1;
      push_g(1, t, 1, 1, 32'h2000, 32'h1234_5678, 4'hF);
      push_r(1, t + 2, 1, 32'h0);
      tick(1);
      b1.d_req_i = 0; b1.d_we_i = 0;
      tick(3);

      // MEM_LAT=3 core read with a debug request queued behind it
      t = cyc;
      b3.c_we_i = 0; b3.c_addr_i = 32'h20; b3.c_wdata_i = 32'h0; b3.c_be_i = 4'hF;
      b3.c_req_i = 1;
      push_g(3, t, 0, 0, 32'h20, 32'h0, 4'hF);
      push_r(3, t + 4, 0, 32'hCAFE_0001);
      chk("busy3_grant_cycle", {31'b0, b3.busy_o}, 32'd0);
      tick(1);
      b3.c_req_i = 0;
      b3.d_we_i = 0; b3.d_addr_i = 32'h30; b3.d_wdata_i = 32'h0; b3.d_be_i = 4'h3;
      b3.d_req_i = 1;
      push_g(3, t + 4, 1, 0, 32'h30, 32'h0, 4'h3);
      push_r(3, t + 8, 1, 32'h5A5A_0030);
      for (int k = 1; k <= 3; k++) begin
         chk("busy3_wait", {31'b0, b3.busy_o}, 32'd1);
         tick(1);
      end
      chk("busy3_done", {31'b0, b3.busy_o}, 32'd0);
      tick(1);
      b3.d_req_i = 0;
      tick(4);

      // Reset during WAIT drops the transaction and clears the starve counter
      t = cyc;
      b3.c_addr_i = 32'h40; b3.c_be_i = 4'hF;
      b3.d_addr_i = 32'h50; b3.d_be_i = 4'hF;
      b3.c_req_i = 1; b3.d_req_i = 1;
      push_g(3, t, 0, 0, 32'h40, 32'h0, 4'hF);
      tick(1);
      b3.c_req_i = 0;
      rst = 1'b1;
      #1;
      chk("rst3_busy", {31'b0, b3.busy_o}, 32'd0);
      chk("rst3_rvalid", {30'b0, b3.c_rvalid_o, b3.d_rvalid_o}, 32'd0);
      chk("rst3_rdata", b3.c_rdata_o | b3.d_rdata_o, 32'd0);
      chk("rst3_gnt", {30'b0, b3.c_gnt_o, b3.d_gnt_o}, 32'd0);
      chk("rst3_mcmd", b3.m_addr_o | b3.m_wdata_o | {26'b0, b3.m_req_o, b3.m_we_o, b3.m_be_o}, 32'd0);
      tick(2);
      rst = 1'b0;
      b3.c_req_i = 1;
      t = cyc;
      push_g(3, t, 0, 0, 32'h40, 32'h0, 4'hF);
      push_r(3, t + 4, 0, 32'h5A5A_0040);
      push_g(3, t + 4, 1, 0, 32'h50, 32'h0, 4'hF);
      push_r(3, t + 8, 1, 32'h5A5A_0050);
      push_g(3, t + 8, 0, 0, 32'h40, 32'h0, 4'hF);
      push_r(3, t + 12, 0, 32'h5A5A_0040);
      tick(9);
      b3.c_req_i = 0; b3.d_req_i = 0;
      tick(6);

      chk("gq1_left", 32'(gq1.size()), 32'd0);
      chk("rq1_left", 32'(rq1.size()), 32'd0);
      chk("gq3_left", 32'(gq3.size()), 32'd0);
      chk("rq3_left", 32'(rq3.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/IO port behind the core's load-store unit between two requesters: the core's LSU (port C) and a debug/program-loader master (port D).
- Allows one outstanding transaction at a time and supports a configurable memory read latency.
- Fixed priority goes to the core, with starvation protection for the debug port and a lock input for loader mode.
- Sits between the LSU and the memory/peripheral array.

Parameters:
- MEM_LAT, 1: cycles from the command cycle until m_rdata_i is valid; legal range 1..4.
- STARVE_MAX, 4: maximum consecutive core grants while D is requesting; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- c_req_i  in  1  core request; held until c_gnt_o
- c_we_i  in  1  core write enable
- c_addr_i  in  32  core byte address
- c_wdata_i  in  32  core write data
- c_be_i  in  4  core byte enables
- c_gnt_o  out  1  core grant pulse (command accepted)
- c_rvalid_o  out  1  core completion pulse
- c_rdata_o  out  32  core read data, qualified by c_rvalid_o
- d_req_i, d_we_i, d_addr_i[31:0], d_wdata_i[31:0], d_be_i[3:0]  in  debug requester, same rules as the core port
- d_gnt_o, d_rvalid_o (1), d_rdata_o (32)  out  debug responses, same rules as the core port
- dbg_lock_i  in  1  when 1, the core is never granted
- m_req_o  out  1  memory command strobe
- m_we_o  out  1  memory write enable
- m_addr_o  out  32  memory address
- m_wdata_o  out  32  memory write data
- m_be_o  out  4  memory byte enables
- m_rdata_i  in  32  memory read data
- busy_o  out  1  1 when state is not IDLE

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State goes to IDLE; wait counter, starve counter, rdata register, rvalid flags and latched owner/we all clear to 0.
  - Every output reads 0 while reset is held.
  - An in-flight transaction is dropped; no rvalid is ever issued for it.
- States: IDLE, WAIT.
- IDLE:
  - If no eligible request, all gnt_o and m_req_o stay 0.
  - Eligibility: C is eligible if c_req_i=1 and dbg_lock_i=0. D is eligible if d_req_i=1.
  - Winner: if both are eligible, D wins when starve_cnt==STARVE_MAX, otherwise C wins. If only one is eligible, it wins.
  - In the grant cycle, combinationally:
    - the winner's gnt_o=1;
    - m_req_o=1;
    - m_we_o/m_addr_o/m_wdata_o/m_be_o are muxed from the winner.
  - When no grant occurs, m_* data outputs are 0.
  - At the clock edge after a grant: latch owner and we, load wait_cnt=MEM_LAT, go to WAIT.
- Starve counter (updated only in grant cycles):
  - C granted while d_req_i=1: starve_cnt+1, saturating at STARVE_MAX.
  - D granted: clear to 0.
  - C granted while d_req_i=0: clear to 0.
- WAIT:
  - m_req_o=0, no grants; wait_cnt decrements each cycle.
  - In the cycle where wait_cnt==1, the block samples m_rdata_i at the edge; for a write it loads 0 instead. Next state is IDLE, and the owner's rvalid flag is set for exactly one cycle.
- Timing:
  - Read data arrives on rdata_o/rvalid_o MEM_LAT+1 cycles after the gnt cycle.
  - The rvalid cycle coincides with IDLE, so a new grant can occur in the same cycle (back-to-back).
  - Throughput is one transaction per MEM_LAT+1 cycles.
- c_rdata_o and d_rdata_o are both driven from the shared rdata register; only the owner's rvalid_o is asserted.
- The rdata register holds its value until the next completion.
- Requesters may change or deassert req and address signals after the gnt cycle; the arbiter does not re-sample them.
- A request that drops before being granted is simply not served.
- dbg_lock_i changes take effect at the next arbitration; an in-flight core transaction still completes.
- busy_o=1 exactly in WAIT.

Test Plan:
- MEM_LAT=1, c_req_i with read at 0x0000_0010, memory returns 0xDEADBEEF -> c_gnt_o=1 at cycle 0 with m_addr_o=0x10 and m_we_o=0; c_rvalid_o=1 at cycle 2 with c_rdata_o=0xDEADBEEF; d_rvalid_o stays 0.
- STARVE_MAX=4, MEM_LAT=1, c_req_i and d_req_i held continuously -> grant order C,C,C,C,D,C,C,C,C,D with grants every 2 cycles.
- dbg_lock_i=1, both ports requesting -> only d_gnt_o pulses; c_gnt_o stays 0 for 20 cycles; dropping lock lets C win the next arbitration.
- D write: addr 0x0000_2000, wdata 0x12345678, be 0xF -> in the d_gnt_o cycle m_req_o=1, m_we_o=1 and m_addr_o/m_wdata_o/m_be_o match; d_rvalid_o pulses MEM_LAT+1 cycles later with d_rdata_o=0.
- MEM_LAT=3, core read, memory returns 0xCAFE0001 -> busy_o=1 for cycles 1..3; c_rvalid_o at cycle 4 with data 0xCAFE0001; a queued d_req_i is granted in cycle 4.
- rst_i asserted mid-WAIT (cycle 1 of a MEM_LAT=3 read) -> all outputs 0 immediately, no rvalid after release; first request after release is granted in its first IDLE cycle with starve_cnt=0.
